// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file writeback arbiter: LL entry layout and
// starvation FSM states.
package wb_arb_pkg;

  localparam int XLEN       = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int LL_ENTRY_W = 37;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } ll_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } starve_state_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// Circular buffer for long-latency writeback results; can retire up to two
// entries per cycle so both idle RF ports can be filled at once.
module wb_ll_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ll_entry_t              push_entry,
  input  logic [1:0]             pop_n,
  output ll_entry_t              head0,
  output ll_entry_t              head1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ll_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // DEPTH is a power of two, so pointer wrap is plain modulo overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges pipe slots A/B and the long-latency return path onto the two rf_xpr
// write ports, with a starvation stall request when LL results cannot drain.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int LL_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wb1_wten,
  input  logic [RF_ADDR_W-1:0] wb1_rd,
  input  logic [XLEN-1:0]      wb1_result,
  input  logic                 wb2_wten,
  input  logic [RF_ADDR_W-1:0] wb2_rd,
  input  logic [XLEN-1:0]      wb2_result,
  input  logic                 wb1_older,
  input  logic                 ll_valid,
  input  logic [RF_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]      ll_result,
  output logic                 ll_ready,
  output logic [XLEN-1:0]      rf_xpr_wrt0_D,
  output logic [RF_ADDR_W-1:0] rf_xpr_wrt0_WA,
  output logic                 rf_xpr_wrt0_WE,
  output logic [XLEN-1:0]      rf_xpr_wrt1_D,
  output logic [RF_ADDR_W-1:0] rf_xpr_wrt1_WA,
  output logic                 rf_xpr_wrt1_WE,
  output logic                 wb_stall_req,
  output logic                 ll_pending
);

  localparam int CNT_W = $clog2(LL_DEPTH) + 1;

  logic             a_eff, b_eff, waw, a_wr, b_wr;
  logic [1:0]       pop_n;
  logic             drained;
  logic             push;
  logic [CNT_W-1:0] count;
  ll_entry_t        head0, head1, push_entry;
  logic [3:0]       starve_cnt;
  starve_state_t    state;

  // On a same-rd collision only the younger slot keeps its write.
  always_comb begin
    a_eff = !RST && wb1_wten && (wb1_rd != '0);
    b_eff = !RST && wb2_wten && (wb2_rd != '0);
    waw   = a_eff && b_eff && (wb1_rd == wb2_rd);
    a_wr  = a_eff && !(waw && wb1_older);
    b_wr  = b_eff && !(waw && !wb1_older);
  end

  always_comb begin
    pop_n = 2'd0;
    if (count != '0) begin
      if (!a_wr && !b_wr && (count >= CNT_W'(2))) pop_n = 2'd2;
      else if (!a_wr || !b_wr)                    pop_n = 2'd1;
    end
  end

  assign drained    = (pop_n != 2'd0);
  assign ll_ready   = !RST && ((count < CNT_W'(LL_DEPTH)) || drained);
  assign push       = ll_valid && ll_ready && (ll_rd != '0);
  assign push_entry = '{rd: ll_rd, data: ll_result};
  assign ll_pending = (count != '0);

  wb_ll_fifo #(
    .DEPTH(LL_DEPTH)
  ) u_ll_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_entry(push_entry),
    .pop_n     (pop_n),
    .head0     (head0),
    .head1     (head1),
    .count     (count)
  );

  // LL head takes the lowest free port; a second entry only rides wrt1 when both are free.
  always_comb begin
    rf_xpr_wrt0_WE = 1'b0;
    rf_xpr_wrt0_WA = '0;
    rf_xpr_wrt0_D  = '0;
    rf_xpr_wrt1_WE = 1'b0;
    rf_xpr_wrt1_WA = '0;
    rf_xpr_wrt1_D  = '0;
    if (a_wr) begin
      rf_xpr_wrt0_WE = 1'b1;
      rf_xpr_wrt0_WA = wb1_rd;
      rf_xpr_wrt0_D  = wb1_result;
    end else if (drained) begin
      rf_xpr_wrt0_WE = 1'b1;
      rf_xpr_wrt0_WA = head0.rd;
      rf_xpr_wrt0_D  = head0.data;
    end
    if (b_wr) begin
      rf_xpr_wrt1_WE = 1'b1;
      rf_xpr_wrt1_WA = wb2_rd;
      rf_xpr_wrt1_D  = wb2_result;
    end else if (pop_n == 2'd2) begin
      rf_xpr_wrt1_WE = 1'b1;
      rf_xpr_wrt1_WA = head1.rd;
      rf_xpr_wrt1_D  = head1.data;
    end else if (drained && a_wr) begin
      rf_xpr_wrt1_WE = 1'b1;
      rf_xpr_wrt1_WA = head0.rd;
      rf_xpr_wrt1_D  = head0.data;
    end
  end

  // The set is gated on no drain so a request cannot latch after the FIFO empties.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_RUN;
      starve_cnt   <= '0;
      wb_stall_req <= 1'b0;
    end else begin
      if ((count == '0) || drained)          starve_cnt <= '0;
      else if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      case (state)
        ST_RUN: begin
          if ((starve_cnt == 4'(STARVE_LIMIT)) && !drained) begin
            state        <= ST_STALL;
            wb_stall_req <= 1'b1;
          end
        end
        ST_STALL: begin
          if (drained) begin
            state        <= ST_RUN;
            wb_stall_req <= 1'b0;
          end
        end
        default: begin
          state        <= ST_RUN;
          wb_stall_req <= 1'b0;
        end
      endcase
    end
  end

  wb_stall_protocol: assert property (@(posedge CLK) disable iff (RST)
    wb_stall_req |-> !(wb1_wten || wb2_wten));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: slot mapping, WAW, LL drain, starvation
// stall and mid-drain reset, each with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        wb1_wten, wb2_wten, wb1_older, ll_valid;
  logic [4:0]  wb1_rd, wb2_rd, ll_rd;
  logic [31:0] wb1_result, wb2_result, ll_result;
  logic        ll_ready, wb_stall_req, ll_pending;
  logic [31:0] rf_xpr_wrt0_D, rf_xpr_wrt1_D;
  logic [4:0]  rf_xpr_wrt0_WA, rf_xpr_wrt1_WA;
  logic        rf_xpr_wrt0_WE, rf_xpr_wrt1_WE;

  int vectors = 0;
  int miscompares = 0;

  wb_port_arbiter #(
    .LL_DEPTH    (2),
    .STARVE_LIMIT(4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .wb1_wten      (wb1_wten),
    .wb1_rd        (wb1_rd),
    .wb1_result    (wb1_result),
    .wb2_wten      (wb2_wten),
    .wb2_rd        (wb2_rd),
    .wb2_result    (wb2_result),
    .wb1_older     (wb1_older),
    .ll_valid      (ll_valid),
    .ll_rd         (ll_rd),
    .ll_result     (ll_result),
    .ll_ready      (ll_ready),
    .rf_xpr_wrt0_D (rf_xpr_wrt0_D),
    .rf_xpr_wrt0_WA(rf_xpr_wrt0_WA),
    .rf_xpr_wrt0_WE(rf_xpr_wrt0_WE),
    .rf_xpr_wrt1_D (rf_xpr_wrt1_D),
    .rf_xpr_wrt1_WA(rf_xpr_wrt1_WA),
    .rf_xpr_wrt1_WE(rf_xpr_wrt1_WE),
    .wb_stall_req  (wb_stall_req),
    .ll_pending    (ll_pending)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL timeout got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_slots(input logic a_en, input logic [4:0] a_rd, input logic [31:0] a_d,
                           input logic b_en, input logic [4:0] b_rd, input logic [31:0] b_d,
                           input logic older);
    wb1_wten = a_en; wb1_rd = a_rd; wb1_result = a_d;
    wb2_wten = b_en; wb2_rd = b_rd; wb2_result = b_d;
    wb1_older = older;
  endtask

  task automatic set_ll(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ll_valid = v; ll_rd = rd; ll_result = d;
  endtask

  task automatic drive_idle;
    set_slots(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_ll(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset;
    set_slots(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b1);
    set_ll(1'b1, 5'd9, 32'h99);
    RST = 1'b1;
    #1;
    vectors++; if (rf_xpr_wrt0_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we0 got %0b want 0", rf_xpr_wrt0_WE); end
    vectors++; if (rf_xpr_wrt1_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we1 got %0b want 0", rf_xpr_wrt1_WE); end
    vectors++; if (rf_xpr_wrt0_D !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_d0 got %h want 0", rf_xpr_wrt0_D); end
    vectors++; if (ll_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready got %0b want 0", ll_ready); end
    tick;
    tick;
    vectors++; if (ll_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pending got %0b want 0", ll_pending); end
    vectors++; if (wb_stall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall got %0b want 0", wb_stall_req); end
    drive_idle;
    RST = 1'b0;
    tick;
  endtask

  task automatic test_dual_slots;
    set_slots(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b1);
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D} !== {1'b1, 5'd5, 32'h11}) begin miscompares++;
      $display("[TB] FAIL dual_wrt0 got we=%0b wa=%0d d=%h want we=1 wa=5 d=11", rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D); end
    vectors++; if ({rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D} !== {1'b1, 5'd6, 32'h22}) begin miscompares++;
      $display("[TB] FAIL dual_wrt1 got we=%0b wa=%0d d=%h want we=1 wa=6 d=22", rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D); end
    vectors++; if (ll_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL dual_ready got %0b want 1", ll_ready); end
    tick;
    drive_idle;
  endtask

  task automatic test_waw;
    set_slots(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b1);
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D} !== {1'b0, 5'd0, 32'h0}) begin miscompares++;
      $display("[TB] FAIL waw_a_old_wrt0 got we=%0b wa=%0d d=%h want we=0 wa=0 d=0", rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D); end
    vectors++; if ({rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D} !== {1'b1, 5'd7, 32'hBB}) begin miscompares++;
      $display("[TB] FAIL waw_a_old_wrt1 got we=%0b wa=%0d d=%h want we=1 wa=7 d=bb", rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D); end
    tick;
    set_slots(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b0);
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D} !== {1'b1, 5'd7, 32'hAA}) begin miscompares++;
      $display("[TB] FAIL waw_b_old_wrt0 got we=%0b wa=%0d d=%h want we=1 wa=7 d=aa", rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D); end
    vectors++; if ({rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D} !== {1'b0, 5'd0, 32'h0}) begin miscompares++;
      $display("[TB] FAIL waw_b_old_wrt1 got we=%0b wa=%0d d=%h want we=0 wa=0 d=0", rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D); end
    tick;
    drive_idle;
  endtask

  task automatic test_ll_dual_drain;
    set_ll(1'b1, 5'd9, 32'h99);
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt1_WE} !== 2'b00) begin miscompares++;
      $display("[TB] FAIL ll_same_cycle got we0=%0b we1=%0b want 0 0", rf_xpr_wrt0_WE, rf_xpr_wrt1_WE); end
    tick;
    set_slots(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1);
    set_ll(1'b1, 5'd10, 32'h1010);
    #1;
    vectors++; if ({rf_xpr_wrt0_WA, rf_xpr_wrt1_WA, ll_pending} !== {5'd1, 5'd2, 1'b1}) begin miscompares++;
      $display("[TB] FAIL ll_slots_own got wa0=%0d wa1=%0d pend=%0b want 1 2 1", rf_xpr_wrt0_WA, rf_xpr_wrt1_WA, ll_pending); end
    tick;
    drive_idle;
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D} !== {1'b1, 5'd9, 32'h99}) begin miscompares++;
      $display("[TB] FAIL ll_drain_wrt0 got we=%0b wa=%0d d=%h want we=1 wa=9 d=99", rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D); end
    vectors++; if ({rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D} !== {1'b1, 5'd10, 32'h1010}) begin miscompares++;
      $display("[TB] FAIL ll_drain_wrt1 got we=%0b wa=%0d d=%h want we=1 wa=10 d=1010", rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D); end
    tick;
    vectors++; if (ll_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL ll_drained_pending got %0b want 0", ll_pending); end
  endtask

  task automatic test_ll_zero_discard;
    set_slots(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1);
    set_ll(1'b1, 5'd0, 32'h5);
    #1;
    vectors++; if (ll_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_ready got %0b want 1", ll_ready); end
    tick;
    drive_idle;
    #1;
    vectors++; if ({ll_pending, rf_xpr_wrt0_WE, rf_xpr_wrt1_WE} !== 3'b000) begin miscompares++;
      $display("[TB] FAIL zero_discard got pend=%0b we0=%0b we1=%0b want 0 0 0", ll_pending, rf_xpr_wrt0_WE, rf_xpr_wrt1_WE); end
    tick;
  endtask

  task automatic test_rd0_slot;
    set_slots(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1);
    set_ll(1'b1, 5'd3, 32'h33);
    tick;
    set_slots(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd4, 32'h44, 1'b1);
    set_ll(1'b0, 5'd0, 32'h0);
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D} !== {1'b1, 5'd3, 32'h33}) begin miscompares++;
      $display("[TB] FAIL rd0_wrt0 got we=%0b wa=%0d d=%h want we=1 wa=3 d=33", rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D); end
    vectors++; if ({rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D} !== {1'b1, 5'd4, 32'h44}) begin miscompares++;
      $display("[TB] FAIL rd0_wrt1 got we=%0b wa=%0d d=%h want we=1 wa=4 d=44", rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D); end
    tick;
    drive_idle;
    #1;
    vectors++; if (ll_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL rd0_pending got %0b want 0", ll_pending); end
    tick;
  endtask

  task automatic test_fill_stall;
    set_slots(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210, 1'b1);
    set_ll(1'b1, 5'd12, 32'hC0C);
    tick;
    set_ll(1'b1, 5'd13, 32'hD0D);
    tick;
    set_ll(1'b0, 5'd0, 32'h0);
    #1;
    vectors++; if ({ll_ready, ll_pending} !== 2'b01) begin miscompares++;
      $display("[TB] FAIL full_ready got ready=%0b pend=%0b want 0 1", ll_ready, ll_pending); end
    vectors++; if ({rf_xpr_wrt0_WA, rf_xpr_wrt1_WA} !== {5'd20, 5'd21}) begin miscompares++;
      $display("[TB] FAIL full_slots_own got wa0=%0d wa1=%0d want 20 21", rf_xpr_wrt0_WA, rf_xpr_wrt1_WA); end
    for (int i = 0; i < 3; i++) tick;
    vectors++; if (wb_stall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_early got %0b want 0", wb_stall_req); end
    tick;
    vectors++; if (wb_stall_req !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_rise got %0b want 1", wb_stall_req); end
    set_slots(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_ll(1'b1, 5'd14, 32'hE0E);
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D} !== {1'b1, 5'd12, 32'hC0C}) begin miscompares++;
      $display("[TB] FAIL full_drain_wrt0 got we=%0b wa=%0d d=%h want we=1 wa=12 d=c0c", rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D); end
    vectors++; if ({rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D} !== {1'b1, 5'd13, 32'hD0D}) begin miscompares++;
      $display("[TB] FAIL full_drain_wrt1 got we=%0b wa=%0d d=%h want we=1 wa=13 d=d0d", rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D); end
    vectors++; if (ll_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_drain_ready got %0b want 1", ll_ready); end
    tick;
    vectors++; if ({wb_stall_req, ll_pending} !== 2'b01) begin miscompares++;
      $display("[TB] FAIL stall_fall got stall=%0b pend=%0b want 0 1", wb_stall_req, ll_pending); end
    set_ll(1'b0, 5'd0, 32'h0);
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D} !== {1'b1, 5'd14, 32'hE0E}) begin miscompares++;
      $display("[TB] FAIL wrap_wrt0 got we=%0b wa=%0d d=%h want we=1 wa=14 d=e0e", rf_xpr_wrt0_WE, rf_xpr_wrt0_WA, rf_xpr_wrt0_D); end
    vectors++; if ({rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D} !== {1'b0, 5'd0, 32'h0}) begin miscompares++;
      $display("[TB] FAIL wrap_wrt1 got we=%0b wa=%0d d=%h want we=0 wa=0 d=0", rf_xpr_wrt1_WE, rf_xpr_wrt1_WA, rf_xpr_wrt1_D); end
    tick;
    vectors++; if (ll_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_pending got %0b want 0", ll_pending); end
  endtask

  task automatic test_reset_mid;
    set_slots(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210, 1'b1);
    set_ll(1'b1, 5'd15, 32'hF0F);
    tick;
    set_ll(1'b1, 5'd16, 32'h1616);
    tick;
    set_ll(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 20 && !wb_stall_req; i++) tick;
    vectors++; if ({wb_stall_req, ll_pending} !== 2'b11) begin miscompares++;
      $display("[TB] FAIL mid_pre_stall got stall=%0b pend=%0b want 1 1", wb_stall_req, ll_pending); end
    RST = 1'b1;
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt1_WE, rf_xpr_wrt0_D, rf_xpr_wrt1_D} !== {2'b00, 64'h0}) begin miscompares++;
      $display("[TB] FAIL mid_rst_ports got we0=%0b we1=%0b d0=%h d1=%h want 0 0 0 0", rf_xpr_wrt0_WE, rf_xpr_wrt1_WE, rf_xpr_wrt0_D, rf_xpr_wrt1_D); end
    vectors++; if ({ll_ready, ll_pending, wb_stall_req} !== 3'b000) begin miscompares++;
      $display("[TB] FAIL mid_rst_ctl got ready=%0b pend=%0b stall=%0b want 0 0 0", ll_ready, ll_pending, wb_stall_req); end
    tick;
    drive_idle;
    RST = 1'b0;
    #1;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt1_WE, ll_ready, ll_pending} !== 4'b0010) begin miscompares++;
      $display("[TB] FAIL mid_release got we0=%0b we1=%0b ready=%0b pend=%0b want 0 0 1 0", rf_xpr_wrt0_WE, rf_xpr_wrt1_WE, ll_ready, ll_pending); end
    tick;
    vectors++; if ({rf_xpr_wrt0_WE, rf_xpr_wrt1_WE, wb_stall_req} !== 3'b000) begin miscompares++;
      $display("[TB] FAIL mid_no_stale got we0=%0b we1=%0b stall=%0b want 0 0 0", rf_xpr_wrt0_WE, rf_xpr_wrt1_WE, wb_stall_req); end
  endtask

  initial begin
    drive_idle;
    #2;
    test_reset;
    test_dual_slots;
    test_waw;
    test_ll_dual_drain;
    test_ll_zero_discard;
    test_rd0_slot;
    test_fill_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
